// File: rtl/rvlab_clken_mgr_if.sv
// Divider bus of the clock-enable manager: per-channel divide programming, enables,
// and the resulting enable pulses and pending-update flags.
interface rvlab_clken_mgr_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    div_update_i;
    logic [NUM_CH-1:0]       ch_en_i;
    logic [NUM_CH-1:0]       clken_o;
    logic [NUM_CH-1:0]       upd_pending_o;

    modport master (
        output div_i, div_update_i, ch_en_i,
        input  clken_o, upd_pending_o
    );

    modport slave (
        input  div_i, div_update_i, ch_en_i,
        output clken_o, upd_pending_o
    );
endinterface

// File: rtl/rvlab_clken_mgr.sv
// Post-MMCM controller: synchronises LOCKED, sequences a lock-qualified reset with
// hold-off, and produces phase-aligned programmable clock-enable pulse trains.
module rvlab_clken_mgr #(
    parameter int NUM_CH          = 4,
    parameter int DIV_W           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int RST_HOLD_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 locked_i,
    input  logic                 lock_lost_clr_i,
    rvlab_clken_mgr_if.slave     bus,
    output logic                 rst_o,
    output logic                 ready_o,
    output logic                 lock_lost_o
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [HOLD_W-1:0]       w_hold_cnt_nxt;
    logic                    w_set_lost;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_locked_s;
    logic                    r_lock_lost;
    logic                    w_run;

    logic [DIV_W-1:0]        r_shadow [NUM_CH];
    logic [DIV_W-1:0]        r_dact   [NUM_CH];
    logic [DIV_W-1:0]        r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]       r_pending;

    logic [DIV_W-1:0]        w_shadow_nxt [NUM_CH];
    logic [DIV_W-1:0]        w_dsel       [NUM_CH];
    logic [DIV_W-1:0]        w_reload     [NUM_CH];
    logic [NUM_CH-1:0]       w_run_ch;
    logic [NUM_CH-1:0]       w_clken;

    assign w_locked_s = r_sync[SYNC_STAGES-1];
    assign w_run      = (r_state == ST_RUN);
    assign rst_o      = (r_state != ST_RUN);
    assign ready_o    = w_run;
    assign lock_lost_o = r_lock_lost;

    assign bus.clken_o       = w_clken;
    assign bus.upd_pending_o = r_pending;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_set_lost     = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_set_lost  = 1'b1;
                end
            end
            default: w_state_nxt = ST_WAIT_LOCK;
        endcase
    end

    // A pending or same-cycle strobe selects the shadow; a divide of 0 reloads like 1.
    always_comb begin
        w_shadow_nxt = '{default: '0};
        w_dsel       = '{default: '0};
        w_reload     = '{default: '0};
        w_run_ch     = '0;
        w_clken      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_shadow_nxt[i] = bus.div_update_i ? bus.div_i[i*DIV_W +: DIV_W] : r_shadow[i];
            w_dsel[i]       = (r_pending[i] || bus.div_update_i) ? w_shadow_nxt[i] : r_dact[i];
            w_reload[i]     = (w_dsel[i] == '0) ? '0 : w_dsel[i] - DIV_W'(1);
            w_run_ch[i]     = w_run && bus.ch_en_i[i];
            w_clken[i]      = w_run_ch[i] && (r_cnt[i] == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_WAIT_LOCK;
            r_hold_cnt  <= '0;
            r_sync      <= '0;
            r_lock_lost <= 1'b0;
            r_pending   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= DIV_W'(1);
                r_dact[i]   <= DIV_W'(1);
                r_cnt[i]    <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_sync     <= {r_sync[SYNC_STAGES-2:0], locked_i};
            if (w_set_lost) begin
                r_lock_lost <= 1'b1;
            end else if (lock_lost_clr_i) begin
                r_lock_lost <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
                if (!w_run_ch[i]) begin
                    r_cnt[i]     <= '0;
                    r_dact[i]    <= w_shadow_nxt[i];
                    r_pending[i] <= 1'b0;
                end else if (r_cnt[i] == '0) begin
                    r_cnt[i]     <= w_reload[i];
                    r_dact[i]    <= w_dsel[i];
                    r_pending[i] <= 1'b0;
                end else begin
                    r_cnt[i] <= r_cnt[i] - DIV_W'(1);
                    if (bus.div_update_i) begin
                        r_pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rvlab_clken_mgr.sv
// Directed bench for rvlab_clken_mgr: lock sequencing, divide ratios, update timing,
// lock loss and mid-run reset, each with hand-computed expectations.
module tb_rvlab_clken_mgr;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int RST_HOLD    = 16;

    logic clk = 1'b0;
    logic rst;
    logic locked;
    logic lock_lost_clr;
    logic rst_o;
    logic ready_o;
    logic lock_lost_o;

    int n_tests = 0;
    int n_fail  = 0;

    rvlab_clken_mgr_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus_if ();

    rvlab_clken_mgr #(
        .NUM_CH(NUM_CH),
        .DIV_W(DIV_W),
        .SYNC_STAGES(SYNC_STAGES),
        .RST_HOLD_CYCLES(RST_HOLD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .locked_i(locked),
        .lock_lost_clr_i(lock_lost_clr),
        .bus(bus_if.slave),
        .rst_o(rst_o),
        .ready_o(ready_o),
        .lock_lost_o(lock_lost_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        locked = 1'b0;
        lock_lost_clr = 1'b0;
        bus_if.div_i = '0;
        bus_if.div_update_i = 1'b0;
        bus_if.ch_en_i = '1;
        tick();
        tick();
        n_tests++; if (rst_o !== 1'b1) begin n_fail++; $display("FAIL reset rst_o got %b exp 1", rst_o); end
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset ready_o got %b exp 0", ready_o); end
        n_tests++; if (bus_if.clken_o !== 4'h0) begin n_fail++; $display("FAIL reset clken got %h exp 0", bus_if.clken_o); end
        n_tests++; if (bus_if.upd_pending_o !== 4'h0) begin n_fail++; $display("FAIL reset pending got %h exp 0", bus_if.upd_pending_o); end
        n_tests++; if (lock_lost_o !== 1'b0) begin n_fail++; $display("FAIL reset lock_lost got %b exp 0", lock_lost_o); end
    endtask

    // locked rises at cycle 0; RUN expected at cycle 2+16+1 = 19. Divides are
    // programmed during WAIT_LOCK so the first RUN cycle uses them.
    task automatic test_lock_seq();
        bus_if.div_i = {8'd0, 8'd3, 8'd2, 8'd1};
        rst = 1'b0;
        locked = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            n_tests++; if (rst_o !== (c < 19)) begin n_fail++; $display("FAIL lock_seq rst_o c=%0d got %b exp %b", c, rst_o, (c < 19)); end
            n_tests++; if (ready_o !== (c == 19)) begin n_fail++; $display("FAIL lock_seq ready_o c=%0d got %b exp %b", c, ready_o, (c == 19)); end
            n_tests++; if (bus_if.clken_o !== ((c == 19) ? 4'hf : 4'h0)) begin n_fail++; $display("FAIL lock_seq clken c=%0d got %h", c, bus_if.clken_o); end
            n_tests++; if (bus_if.upd_pending_o !== 4'h0) begin n_fail++; $display("FAIL lock_seq pending c=%0d got %h exp 0", c, bus_if.upd_pending_o); end
            if (c == 1) bus_if.div_update_i = 1'b1;
            if (c == 2) bus_if.div_update_i = 1'b0;
            if (c < 19) tick();
        end
    endtask

    task automatic test_divide();
        logic [3:0] exp;
        for (int k = 0; k < 12; k++) begin
            exp = {1'b1, (k % 3 == 0), (k % 2 == 0), 1'b1};
            n_tests++; if (bus_if.clken_o !== exp) begin n_fail++; $display("FAIL divide k=%0d got %h exp %h", k, bus_if.clken_o, exp); end
            tick();
        end
    endtask

    // ch2 re-enabled with D=5 pulses at T; strobe D=2 at T+2 applies at T+5.
    task automatic test_update();
        bus_if.ch_en_i[2] = 1'b0;
        #1;
        n_tests++; if (bus_if.clken_o[2] !== 1'b0) begin n_fail++; $display("FAIL update disabled clken2 got %b exp 0", bus_if.clken_o[2]); end
        bus_if.div_i = {8'd0, 8'd5, 8'd2, 8'd1};
        bus_if.div_update_i = 1'b1;
        tick();
        bus_if.div_update_i = 1'b0;
        tick();
        bus_if.ch_en_i[2] = 1'b1;
        #1;
        n_tests++; if (bus_if.clken_o[2] !== 1'b1) begin n_fail++; $display("FAIL update reenable clken2 got %b exp 1", bus_if.clken_o[2]); end
        for (int j = 1; j <= 10; j++) begin
            tick();
            n_tests++; if (bus_if.clken_o[2] !== (j == 5 || j == 7 || j == 9)) begin n_fail++; $display("FAIL update clken2 j=%0d got %b", j, bus_if.clken_o[2]); end
            n_tests++; if (bus_if.upd_pending_o[2] !== (j >= 3 && j <= 5)) begin n_fail++; $display("FAIL update pending2 j=%0d got %b", j, bus_if.upd_pending_o[2]); end
            if (j == 2) begin
                bus_if.div_i = {8'd0, 8'd2, 8'd2, 8'd1};
                bus_if.div_update_i = 1'b1;
            end
            if (j == 3) bus_if.div_update_i = 1'b0;
        end
    endtask

    // locked low during cycle 5 only: back to WAIT_LOCK at 8, HOLD 9..24, RUN at 25.
    task automatic test_hold_glitch();
        rst = 1'b1;
        locked = 1'b0;
        bus_if.ch_en_i = '1;
        tick();
        tick();
        rst = 1'b0;
        locked = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            n_tests++; if (rst_o !== (c < 25)) begin n_fail++; $display("FAIL hold_glitch rst_o c=%0d got %b exp %b", c, rst_o, (c < 25)); end
            n_tests++; if (ready_o !== (c == 25)) begin n_fail++; $display("FAIL hold_glitch ready_o c=%0d got %b", c, ready_o); end
            n_tests++; if (lock_lost_o !== 1'b0) begin n_fail++; $display("FAIL hold_glitch lock_lost c=%0d got %b exp 0", c, lock_lost_o); end
            if (c == 5) locked = 1'b0;
            if (c == 6) locked = 1'b1;
            if (c < 25) tick();
        end
        n_tests++; if (bus_if.clken_o !== 4'hf) begin n_fail++; $display("FAIL hold_glitch first RUN clken got %h exp f", bus_if.clken_o); end
    endtask

    task automatic test_lock_lost();
        tick();
        tick();
        locked = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            tick();
            n_tests++; if (rst_o !== (d == 3)) begin n_fail++; $display("FAIL lock_lost rst_o d=%0d got %b", d, rst_o); end
            n_tests++; if (ready_o !== (d != 3)) begin n_fail++; $display("FAIL lock_lost ready_o d=%0d got %b", d, ready_o); end
            n_tests++; if (bus_if.clken_o !== ((d == 3) ? 4'h0 : 4'hf)) begin n_fail++; $display("FAIL lock_lost clken d=%0d got %h", d, bus_if.clken_o); end
            n_tests++; if (lock_lost_o !== (d == 3)) begin n_fail++; $display("FAIL lock_lost flag d=%0d got %b", d, lock_lost_o); end
        end
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        n_tests++; if (lock_lost_o !== 1'b0) begin n_fail++; $display("FAIL lock_lost clear got %b exp 0", lock_lost_o); end
        locked = 1'b1;
        for (int c = 1; c <= 18; c++) tick();
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL relock ready_o c=18 got %b exp 0", ready_o); end
        tick();
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL relock ready_o c=19 got %b exp 1", ready_o); end
        tick();
        locked = 1'b0;
        tick();
        tick();
        n_tests++; if (lock_lost_o !== 1'b0) begin n_fail++; $display("FAIL lock_lost before set got %b exp 0", lock_lost_o); end
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        n_tests++; if (lock_lost_o !== 1'b1) begin n_fail++; $display("FAIL lock_lost set-vs-clr got %b exp 1", lock_lost_o); end
        n_tests++; if (rst_o !== 1'b1) begin n_fail++; $display("FAIL lock_lost rst_o after set got %b exp 1", rst_o); end
    endtask

    task automatic test_rst_mid();
        locked = 1'b1;
        for (int c = 1; c <= 19; c++) tick();
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid relock ready got %b exp 1", ready_o); end
        bus_if.div_i = {8'd4, 8'd4, 8'd4, 8'd4};
        bus_if.div_update_i = 1'b1;
        tick();
        bus_if.div_i = {8'd7, 8'd7, 8'd7, 8'd7};
        n_tests++; if (bus_if.upd_pending_o !== 4'h0) begin n_fail++; $display("FAIL rst_mid immediate apply pending got %h exp 0", bus_if.upd_pending_o); end
        n_tests++; if (bus_if.clken_o !== 4'h0) begin n_fail++; $display("FAIL rst_mid D=4 clken got %h exp 0", bus_if.clken_o); end
        tick();
        bus_if.div_update_i = 1'b0;
        n_tests++; if (bus_if.upd_pending_o !== 4'hf) begin n_fail++; $display("FAIL rst_mid pending got %h exp f", bus_if.upd_pending_o); end
        rst = 1'b1;
        tick();
        n_tests++; if (rst_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid rst_o got %b exp 1", rst_o); end
        n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid ready_o got %b exp 0", ready_o); end
        n_tests++; if (bus_if.upd_pending_o !== 4'h0) begin n_fail++; $display("FAIL rst_mid pending after rst got %h exp 0", bus_if.upd_pending_o); end
        n_tests++; if (bus_if.clken_o !== 4'h0) begin n_fail++; $display("FAIL rst_mid clken after rst got %h exp 0", bus_if.clken_o); end
        rst = 1'b0;
        for (int c = 1; c <= 19; c++) tick();
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid post-reset ready got %b exp 1", ready_o); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (bus_if.clken_o !== 4'hf) begin n_fail++; $display("FAIL rst_mid div1 k=%0d got %h exp f", k, bus_if.clken_o); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_divide();
        test_update();
        test_hold_glitch();
        test_lock_lost();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvlab_clken_mgr.md
Name: rvlab_clken_mgr

Overview:
Post-MMCM clock-domain controller for the system clock. It synchronises the MMCM lock flag and sequences a lock-qualified synchronous reset with a hold-off count. It also generates NUM_CH independent, phase-aligned clock-enable pulse trains with run-time programmable divide ratios. Sits directly behind the clock manager; downstream slow peripherals use clken_o[i] instead of extra BUFGs/MMCM outputs.

Parameters:
NUM_CH, 4, number of clock-enable channels (1..16)
DIV_W, 8, width of each channel divide value
SYNC_STAGES, 2, flop stages synchronising locked_i (>=2)
RST_HOLD_CYCLES, 16, cycles rst_o stays asserted after synchronised lock (>=1)

Ports:
clk_i  in  1  system clock (sys clock after BUFGCE)
rst_i  in  1  synchronous active-high reset
locked_i  in  1  MMCM LOCKED, asynchronous to clk_i
div_i  in  NUM_CH*DIV_W  per-channel divide values, channel i at [i*DIV_W +: DIV_W]
div_update_i  in  1  single-cycle strobe: capture div_i into shadow registers
ch_en_i  in  NUM_CH  per-channel enable
clken_o  out  NUM_CH  per-channel clock-enable pulses
rst_o  out  1  synchronous active-high reset for downstream logic
ready_o  out  1  high while in RUN
upd_pending_o  out  NUM_CH  shadow value not yet applied to channel
lock_lost_o  out  1  sticky: lock dropped while in RUN
lock_lost_clr_i  in  1  clears lock_lost_o

Behaviour:
- Reset is synchronous, active-high. On rst_i: state=WAIT_LOCK, sync chain=0, hold counter=0, all shadow/active divides=1, counters=0, upd_pending_o=0, lock_lost_o=0, clken_o=0, rst_o=1, ready_o=0. rst_i mid-operation aborts everything identically.
- locked_s = locked_i after SYNC_STAGES flops.
- FSM:
  - WAIT_LOCK: locked_s=1 -> HOLD, hold counter=0.
  - HOLD: counter increments; locked_s=0 -> WAIT_LOCK; counter==RST_HOLD_CYCLES-1 -> RUN. HOLD lasts exactly RST_HOLD_CYCLES cycles.
  - RUN: locked_s=0 -> WAIT_LOCK and set lock_lost_o.
- rst_o = (state!=RUN); ready_o = (state==RUN). Both decoded from the registered state, no combinational path from locked_i. Latency from locked_i rise to rst_o fall is SYNC_STAGES+RST_HOLD_CYCLES+1 cycles.
- lock_lost_o: set has priority over lock_lost_clr_i in the same cycle.
- Divide semantics, per channel: D=0 or 1 gives clken every cycle. D>=2 gives one pulse every D cycles, duty 1/D.
- Counter cnt (DIV_W bits): clken_o[i] = RUN & ch_en_i[i] & (cnt==0), combinational from registers and ch_en_i.
  - When pulsing: cnt <= max(Dact,1)-1.
  - Otherwise: cnt <= cnt-1.
- Outside RUN, or with ch_en_i[i]=0: cnt held at 0, Dact <= shadow, upd_pending cleared. The first RUN cycle therefore pulses on all enabled channels (phase aligned).
- div_update_i: all shadows <= div_i, and upd_pending_o[i]=1 for running channels. The new value is applied glitch-free at that channel's next cnt==0: Dact <= shadow, and the reload uses the new value.
- A strobe coinciding with cnt==0 applies in that same cycle.
- A second strobe before application overwrites the shadow; only the latest is applied.
- ch_en_i deasserted mid-period truncates the period. Re-enable pulses immediately.

Test Plan:
- Reset, locked_i=1 at cycle 0, SYNC_STAGES=2, RST_HOLD_CYCLES=16 -> rst_o falls and ready_o rises exactly at cycle 19; clken_o all 0 before then.
- RUN, div={1,2,3,0}, all enabled -> ch0 pulses every cycle, ch1 every 2nd, ch2 every 3rd, ch3 every cycle; all four pulse on the first RUN cycle.
- ch2 D=5 running, div_update_i with D=2 two cycles after a pulse -> upd_pending_o[2]=1 until the pulse 5 cycles after the previous one, then pulses every 2 cycles; no shortened interval.
- locked_i dropped for 1 cycle during HOLD -> FSM returns to WAIT_LOCK, lock_lost_o stays 0, full 16-cycle hold repeats.
- locked_i dropped in RUN -> rst_o=1 and clken_o=0 SYNC_STAGES+1 cycles later, lock_lost_o=1. lock_lost_clr_i pulse clears it; a clear coincident with a new set leaves it at 1.
- rst_i asserted in RUN with pending updates -> next cycle rst_o=1, upd_pending_o=0, and after relock all channels divide by 1.
